// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and constants for unified_mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_GRANT_I = 2'd1, ST_GRANT_D = 2'd2} state_t;
  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam logic [3:0] INST_MASK = 4'b1111;
endpackage

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: round-robin sharing of one memory bus between fetch and load/store ports
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_valid,
  output logic [31:0] inst_rdata,
  input  logic        data_rd,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_mask,
  input  logic [31:0] data_wdata,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_mask,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        bus_error
);
  localparam int CNT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t state;
  logic last_grant;
  logic [CNT_W-1:0] wait_cnt;
  logic i_pend, d_pend, pick_i, pick_d, timeout_hit, done;
  // a side whose valid is high this cycle still shows its stale request, so it is masked
  always_comb begin
    i_pend = inst_req && !inst_valid;
    d_pend = (data_rd || data_wr) && !data_valid;
    pick_i = i_pend && (!d_pend || last_grant == GNT_D);
    pick_d = d_pend && !pick_i;
    timeout_hit = TIMEOUT != 0 && state != ST_IDLE && !mem_ack && wait_cnt == CNT_W'(TIMEOUT);
    done = state != ST_IDLE && (mem_ack || timeout_hit);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      last_grant <= GNT_D;
      wait_cnt <= '0;
      inst_valid <= 1'b0;
      inst_rdata <= '0;
      data_valid <= 1'b0;
      data_rdata <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_mask <= '0;
      mem_wdata <= '0;
      bus_error <= 1'b0;
    end else begin
      inst_valid <= 1'b0;
      data_valid <= 1'b0;
      if (state == ST_IDLE) begin
        wait_cnt <= '0;
        if (pick_i || pick_d) begin
          state <= pick_i ? ST_GRANT_I : ST_GRANT_D;
          last_grant <= pick_i ? GNT_I : GNT_D;
          mem_req <= 1'b1;
          mem_we <= pick_d && data_wr;
          mem_addr <= pick_i ? inst_addr : data_addr;
          mem_mask <= pick_i ? INST_MASK : data_mask;
          mem_wdata <= pick_i ? '0 : data_wdata;
        end
      end else if (done) begin
        state <= ST_IDLE;
        mem_req <= 1'b0;
        if (state == ST_GRANT_I) begin
          inst_valid <= 1'b1;
          inst_rdata <= timeout_hit ? '0 : mem_rdata;
        end else begin
          data_valid <= 1'b1;
          data_rdata <= timeout_hit ? '0 : mem_rdata;
        end
        if (timeout_hit) bus_error <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end
endmodule
